// File: rtl/trigb_pkg.sv
// Shared types and constants for the predictor coefficient trigger scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package trigb_pkg;

  localparam int NCOEF  = 8;   // coefficients per channel: A1, A2, B1..B6
  localparam int COEF_W = 16;  // coefficient word width
  localparam int IDX_W  = 3;   // coefficient index width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Coefficient slot order inside a channel's 8-word RAM block.
  typedef enum logic [IDX_W-1:0] {
    IDX_A1 = 3'd0,
    IDX_A2 = 3'd1,
    IDX_B1 = 3'd2,
    IDX_B2 = 3'd3,
    IDX_B3 = 3'd4,
    IDX_B4 = 3'd5,
    IDX_B5 = 3'd6,
    IDX_B6 = 3'd7
  } coef_idx_e;

endpackage

// File: rtl/trigb_sched_trigb.sv
// TRIGB: forces a predictor coefficient to zero when a transition is detected.
// Latency: combinational, AnR follows TR/AnP in the same cycle.
// Backpressure: none; pure function of its inputs.
//
// Ports: clk, reset (active-low, async) and scan_in0..4/scan_enable/test_mode
// are the DFT hookups; scan_out0..4 return the scan path. tr/anp in, anr out.
module trigb (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          scan_in0,
  input  logic                          scan_in1,
  input  logic                          scan_in2,
  input  logic                          scan_in3,
  input  logic                          scan_in4,
  input  logic                          scan_enable,
  input  logic                          test_mode,
  output logic                          scan_out0,
  output logic                          scan_out1,
  output logic                          scan_out2,
  output logic                          scan_out3,
  output logic                          scan_out4,
  input  logic                          tr,
  input  logic [trigb_pkg::COEF_W-1:0]  anp,
  output logic [trigb_pkg::COEF_W-1:0]  anr
);

  // No state of its own: the scan path is a gated feed-through that only
  // carries data while the part is in scan test.
  logic scan_path_en;
  assign scan_path_en = test_mode & scan_enable;

  assign scan_out0 = scan_path_en & scan_in0;
  assign scan_out1 = scan_path_en & scan_in1;
  assign scan_out2 = scan_path_en & scan_in2;
  assign scan_out3 = scan_path_en & scan_in3;
  assign scan_out4 = scan_path_en & scan_in4;

  assign anr = tr ? '0 : anp;

  // Clock and reset exist only so the DFT stitching sees a uniform port set.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;

endmodule

// File: rtl/trigb_sched.sv
// Sequences one channel's 8 predictor coefficients through TRIGB: read, capture, write back.
// Latency: 25 cycles per pass (3 per coefficient + DONE); next start accepted 26 edges later.
// Backpressure: start is dropped (not queued) while busy; RAM has fixed 1-cycle read latency.
//
// Ports: clk/reset (active-low, async); DFT scan_in0..4, scan_enable, test_mode,
// scan_out0..4; request start/chan/tr; status busy/done; coefficient RAM
// mem_addr/mem_rd/mem_rdata (valid the cycle after mem_rd)/mem_wr/mem_wdata.
module trigb_sched #(
  parameter int NCH   = 32,
  parameter int NCOEF = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         scan_in0,
  input  logic                                         scan_in1,
  input  logic                                         scan_in2,
  input  logic                                         scan_in3,
  input  logic                                         scan_in4,
  input  logic                                         scan_enable,
  input  logic                                         test_mode,
  output logic                                         scan_out0,
  output logic                                         scan_out1,
  output logic                                         scan_out2,
  output logic                                         scan_out3,
  output logic                                         scan_out4,
  input  logic                                         start,
  input  logic [$clog2(NCH)-1:0]                       chan,
  input  logic                                         tr,
  output logic                                         busy,
  output logic                                         done,
  output logic [$clog2(NCH)+trigb_pkg::IDX_W-1:0]      mem_addr,
  output logic                                         mem_rd,
  input  logic [trigb_pkg::COEF_W-1:0]                 mem_rdata,
  output logic                                         mem_wr,
  output logic [trigb_pkg::COEF_W-1:0]                 mem_wdata
);

  import trigb_pkg::*;

  localparam int                CH_W     = $clog2(NCH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NCOEF - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    coef_idx_q, coef_idx_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic                tr_q, tr_d;
  logic [COEF_W-1:0]   anp_q, anp_d;
  logic [COEF_W-1:0]   anr;

  trigb u_trigb (
    .clk         (clk),
    .reset       (reset),
    .scan_in0    (scan_in0),
    .scan_in1    (scan_in1),
    .scan_in2    (scan_in2),
    .scan_in3    (scan_in3),
    .scan_in4    (scan_in4),
    .scan_enable (scan_enable),
    .test_mode   (test_mode),
    .scan_out0   (scan_out0),
    .scan_out1   (scan_out1),
    .scan_out2   (scan_out2),
    .scan_out3   (scan_out3),
    .scan_out4   (scan_out4),
    .tr          (tr_q),
    .anp         (anp_q),
    .anr         (anr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      coef_idx_q <= '0;
      chan_q     <= '0;
      tr_q       <= 1'b0;
      anp_q      <= '0;
    end else begin
      state_q    <= state_d;
      coef_idx_q <= coef_idx_d;
      chan_q     <= chan_d;
      tr_q       <= tr_d;
      anp_q      <= anp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    coef_idx_d = coef_idx_q;
    chan_d     = chan_q;
    tr_d       = tr_q;
    anp_d      = anp_q;

    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        // Request fields are only sampled here, so a start seen mid-pass
        // can never disturb the channel being worked on.
        if (start) begin
          state_d    = ST_READ;
          coef_idx_d = IDX_A1;
          chan_d     = chan;
          tr_d       = tr;
        end
      end
      ST_READ: begin
        mem_rd   = 1'b1;
        mem_addr = {chan_q, coef_idx_q};
        state_d  = ST_CAPT;
      end
      ST_CAPT: begin
        // Read data arrives this cycle; hold it so TRIGB sees a stable AnP
        // during the write.
        mem_addr = {chan_q, coef_idx_q};
        anp_d    = mem_rdata;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        mem_wr     = 1'b1;
        mem_addr   = {chan_q, coef_idx_q};
        mem_wdata  = anr;
        coef_idx_d = coef_idx_q + 1'b1;
        // The last index exits to DONE, so the counter rolling over to 0
        // never starts a ninth read.
        state_d    = (coef_idx_q == LAST_IDX) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/trigb_sched.md
TRIGB_SCHED -- requirements
Module: trigb_sched

Interface
REQ-001 SHALL have parameter NCH, default 32, meaning number of ADPCM channels sharing the block (power of 2, 2..32).
REQ-002 SHALL have parameter NCOEF, default 8, meaning predictor coefficients per channel (A1, A2, B1..B6; fixed 8).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 scan_in0..scan_in4, scan_enable, test_mode  input  1 each  DFT; passed to the TRIGB instance.
REQ-006 scan_out0..scan_out4  output  1 each  DFT; from the TRIGB instance.
REQ-007 start  input  1  request a coefficient-trigger pass for one channel.
REQ-008 chan  input  log2(NCH)  channel index, sampled with start.
REQ-009 tr  input  1  transition-detect flag for that channel, sampled with start.
REQ-010 busy  output  1  pass in progress.
REQ-011 done  output  1  one-cycle pulse, pass complete.
REQ-012 mem_addr  output  log2(NCH)+3  coefficient RAM address = {chan_q, coef_idx}.
REQ-013 mem_rd  output  1  RAM read strobe; read data valid on the next cycle.
REQ-014 mem_rdata  input  16  RAM read data (AnP).
REQ-015 mem_wr  output  1  RAM write strobe.
REQ-016 mem_wdata  output  16  RAM write data (AnR).

Function
REQ-017 SHALL implement FSM states IDLE, READ, CAPT, WRITE, DONE.
- IDLE -> READ when start=1.
- READ -> CAPT.
- CAPT -> WRITE.
- WRITE -> READ if coef_idx<7, else DONE.
- DONE -> IDLE.
REQ-018 SHALL latch chan into chan_q and tr into tr_q on the edge that accepts start; both are held constant for the whole pass.
REQ-019 SHALL ignore start while busy=1; no queueing of requests.
REQ-020 SHALL clear coef_idx to 0 on start acceptance and increment it on leaving WRITE; the 3-bit counter SHALL NOT wrap into a new read.
REQ-021 SHALL assert mem_rd=1 only in READ, with mem_addr={chan_q, coef_idx}.
REQ-022 In CAPT, SHALL register mem_rdata into anp_q, which drives TRIGB AnP; TRIGB TR SHALL be driven by tr_q.
REQ-023 In WRITE, SHALL assert mem_wr=1 with mem_wdata=TRIGB AnR (0x0000 if tr_q=1, else anp_q) and the same mem_addr.
REQ-024 SHALL write back every coefficient, including unchanged ones when tr_q=0.
REQ-025 busy SHALL equal (state!=IDLE); done SHALL be 1 only in DONE.
REQ-026 Latency: with start accepted at edge 0, coefficient k SHALL be read in cycle 3k+1 and written in cycle 3k+3; done SHALL be high in cycle 25; a new start SHALL be accepted at edge 26 at the earliest.
REQ-027 mem_rd and mem_wr SHALL never be high in the same cycle; mem_addr, mem_wdata, mem_rd and mem_wr SHALL be 0 in IDLE and DONE.

Reset
REQ-028 On reset=0, the block SHALL asynchronously force state=IDLE, coef_idx=0, chan_q=0, tr_q=0, anp_q=0, busy=0, done=0, mem_rd=0, mem_wr=0, mem_addr=0 and mem_wdata=0.
REQ-029 Reset asserted mid-pass SHALL abort the pass; any write not yet strobed is dropped, no done pulse is issued, and the block is idle on release.

Structure
REQ-030 Package trigb_pkg SHALL hold the state enumeration, NCOEF=8, COEF_W=16, IDX_W=3 and coefficient index names (A1=0, A2=1, B1..B6=2..7).
REQ-031 SHALL instantiate exactly one existing TRIGB module as sub-module (TR, AnP in; AnR out; clk, reset and scan ports passed through); no other sub-modules.

Verification
REQ-032 Scenario 1: RAM ch3 preloaded 0x1234..0x123B, start with chan=3, tr=0 -> 8 writes at addr 0x18..0x1F with the same values, done at cycle 25.
REQ-033 Scenario 2: same preload, start with chan=3, tr=1 -> 8 writes of 0x0000 to 0x18..0x1F; other channels untouched.
REQ-034 Scenario 3: start pulsed at cycles 5 and 10 of a pass for chan=7 -> both ignored, single done, no ch7 accesses.
REQ-035 Scenario 4: reset=0 at cycle 11 of a tr=1 pass on chan=1 -> outputs 0 immediately, only coefficients 0..2 zeroed, no done pulse.
REQ-036 Scenario 5: back-to-back start at edge 26 for chan=31 (NCH=32) -> addr 0xF8..0xFF accessed, mem_rd/mem_wr never overlap, second done at cycle 51.
